// File: rtl/io_ctrl_dma.sv
// io_ctrl_dma: CPU-side I/O block for the NES core.
// Serves the $4014 sprite-DMA trigger, the $4016 controller strobe, the serial
// pad reads at $4016/$4017 and a busy status byte at $4018. The DMA engine copies
// DMALEN bytes from page {page,00} to DMADST, one read/write pair per byte, and
// freezes the CPU (halt) for as long as it owns the bus.
module io_ctrl_dma #(
    parameter int          NPAD   = 2,
    parameter int          DMALEN = 256,
    parameter logic [15:0] DMADST = 16'h2004,
    parameter logic [7:0]  SIG0   = 8'h10,
    parameter logic [7:0]  SIG1   = 8'h20,
    parameter bit          ALIGN  = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tick,
    input  logic [4:0]        memaddr,
    input  logic [7:0]        memwdata,
    input  logic              memwr,
    input  logic              ioreq,
    output logic [7:0]        iordata,
    output logic              ioack,
    output logic              halt,
    output logic [15:0]       dmaaddr,
    output logic [7:0]        dmawdata,
    output logic              dmawr,
    output logic              dmareq,
    input  logic              dmaack,
    input  logic [7:0]        memrdata,
    input  logic [8*NPAD-1:0] pads
);

    // Four-player adapter: each port streams two pads followed by a signature byte.
    localparam int         SW   = (NPAD == 4) ? 24 : 8;
    localparam logic [7:0] LAST = 8'(DMALEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_WAIT  = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_parity, r_busy, r_strobe, r_ioack, r_acked;
    logic          r_dmareq, r_dmawr;
    logic [7:0]    r_iordata, r_page, r_src_lo, r_cnt, r_dmawdata;
    logic [15:0]   r_dmaaddr;
    logic [SW-1:0] r_sh0, r_sh1;
    logic [SW-1:0] w_ld0, w_ld1;
    logic          w_acc, w_rd, w_wr;
    logic          w_ack_ok, w_done, w_move, w_last;
    logic          w_halt, w_req_nxt, w_wr_nxt;
    logic [15:0]   w_addr_nxt;

    generate
        if (NPAD == 4) begin : g_four
            assign w_ld0 = {pads[7:0],  pads[23:16], SIG0};
            assign w_ld1 = {pads[15:8], pads[31:24], SIG1};
        end else begin : g_two
            assign w_ld0 = pads[7:0];
            assign w_ld1 = pads[15:8];
        end
    endgenerate

    // A request is accepted only when ack is low, so ack never repeats back to back.
    assign w_acc = ioreq & ~r_ioack;
    assign w_rd  = w_acc & ~memwr;
    assign w_wr  = w_acc &  memwr;

    // An ack only counts while our request is actually on the bus.
    assign w_ack_ok = dmaack & r_dmareq;
    assign w_done   = r_acked | w_ack_ok;
    assign w_move   = (w_state_nxt != r_state);
    assign w_last   = w_move && (r_state == S_WRITE) && (w_state_nxt == S_IDLE);

    // CPU-cycle parity, used to align the DMA start to an even cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     r_parity <= 1'b0;
        else if (tick) r_parity <= ~r_parity;
    end

    // CPU register port: one-clk ack, read data registered alongside it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ioack   <= 1'b0;
            r_iordata <= 8'h00;
            r_strobe  <= 1'b0;
        end else begin
            r_ioack   <= w_acc;
            r_iordata <= 8'h00;
            if (w_rd) begin
                case (memaddr)
                    5'h16:   r_iordata <= {7'b0, r_sh0[SW-1]};
                    5'h17:   r_iordata <= {7'b0, r_sh1[SW-1]};
                    5'h18:   r_iordata <= {7'b0, r_busy};
                    default: r_iordata <= 8'h00;
                endcase
            end
            if (w_wr && memaddr == 5'h16) r_strobe <= memwdata[0];
        end
    end

    // Controller shifters: reload continuously while strobed, else shift on read with 1 fill.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sh0 <= '1;
            r_sh1 <= '1;
        end else if (r_strobe) begin
            r_sh0 <= w_ld0;
            r_sh1 <= w_ld1;
        end else begin
            if (w_rd && memaddr == 5'h16) r_sh0 <= {r_sh0[SW-2:0], 1'b1};
            if (w_rd && memaddr == 5'h17) r_sh1 <= {r_sh1[SW-2:0], 1'b1};
        end
    end

    // DMA trigger: accepted only from a quiet engine; cleared when the last byte lands.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= 1'b0;
            r_page <= 8'h00;
        end else if (w_wr && memaddr == 5'h14 && !r_busy && r_state == S_IDLE) begin
            r_busy <= 1'b1;
            r_page <= memwdata;
        end else if (w_last) begin
            r_busy <= 1'b0;
        end
    end

    // DMA state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // DMA next state: moves only on CPU ticks; READ/WRITE wait for their ack.
    always_comb begin
        w_state_nxt = r_state;
        if (tick) begin
            case (r_state)
                S_IDLE:  if (r_busy) w_state_nxt = S_HALT;
                S_HALT:  w_state_nxt = (ALIGN && r_parity) ? S_WAIT : S_READ;
                S_WAIT:  w_state_nxt = S_READ;
                S_READ:  if (w_done) w_state_nxt = S_WRITE;
                S_WRITE: if (w_done) w_state_nxt = (r_cnt == LAST) ? S_IDLE : S_READ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // DMA outputs: halt from state; next-cycle bus request, address and direction.
    always_comb begin
        w_halt     = (r_state != S_IDLE);
        w_req_nxt  = 1'b0;
        w_wr_nxt   = 1'b0;
        w_addr_nxt = 16'h0000;
        case (r_state)
            S_READ: begin
                w_addr_nxt = {r_page, r_src_lo};
                w_req_nxt  = !w_move && !w_done;
            end
            S_WRITE: begin
                w_addr_nxt = DMADST;
                w_wr_nxt   = 1'b1;
                w_req_nxt  = !w_move && !w_done;
            end
            default: ;
        endcase
    end

    // DMA bus registers; the ack flag is per phase and clears on every state change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dmareq   <= 1'b0;
            r_dmawr    <= 1'b0;
            r_dmaaddr  <= 16'h0000;
            r_dmawdata <= 8'h00;
            r_acked    <= 1'b0;
        end else begin
            r_dmareq  <= w_req_nxt;
            r_dmawr   <= w_wr_nxt;
            r_dmaaddr <= w_addr_nxt;
            if (w_ack_ok && r_state == S_READ) r_dmawdata <= memrdata;
            if (w_move)        r_acked <= 1'b0;
            else if (w_ack_ok) r_acked <= 1'b1;
        end
    end

    // Byte counter and source low byte; the source wraps inside the page.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= 8'h00;
            r_src_lo <= 8'h00;
        end else if (tick && r_state == S_HALT) begin
            r_cnt    <= 8'h00;
            r_src_lo <= 8'h00;
        end else if (w_move && r_state == S_WRITE && w_state_nxt == S_READ) begin
            r_cnt    <= r_cnt + 8'd1;
            r_src_lo <= r_src_lo + 8'd1;
        end
    end

    assign iordata  = r_iordata;
    assign ioack    = r_ioack;
    assign halt     = w_halt;
    assign dmaaddr  = r_dmaaddr;
    assign dmawdata = r_dmawdata;
    assign dmawr    = r_dmawr;
    assign dmareq   = r_dmareq;

endmodule
